shift_rotate_seq: RTL and testbench

//  Sequencer directly upstream of the combinational 32-bit rotate-right datapath in the ALU.

---
 rtl/shift_rotate_seq.sv | 235 +++++++++++++++++++++++
 tb/tb_shift_rotate_seq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_rotate_seq.sv
// ============================================================================
// shift_rotate_seq
// ----------------------------------------------------------------------------
// Purpose:
//   This sequencer sits directly in front of the ALU's combinational 32-bit
//   rotate-right datapath. It accepts one shift or rotate request at a time
//   and stages the operand and the amount. It then drives the rotator's data
//   and amount inputs. The rotator output is turned into a ROR, ROL, SHR, SHL
//   or SHRA result, and the result is held under a valid/ack handshake until
//   the Z-register write takes it.
//
// Operation flow (one request):
//   edge k   : start accepted in IDLE; opcode, operand and count staged
//   edge k+1 : rot_in and rot_amt registered, so the rotator is driven (EXEC)
//   edge k+2 : result registered from rot_out; result_valid rises (HOLD)
//   edge m   : result_ack seen in HOLD; valid clears; back to IDLE
//
// Ports:
//   clock         in   1       rising-edge clock
//   clear         in   1       asynchronous active-low reset
//   start         in   1       request strobe, accepted only while ready=1
//   ready         out  1       high in IDLE
//   opcode        in   3       000 ROR, 001 ROL, 010 SHR, 011 SHL, 100 SHRA
//   operand       in   DATA_W  value to shift or rotate
//   count         in   CNT_W   amount; 32..63 are legal
//   rot_in        out  DATA_W  rotator data input
//   rot_amt       out  5       rotator rotate-right amount
//   rot_out       in   DATA_W  rotator output
//   result        out  DATA_W  registered result
//   result_valid  out  1       result held valid until acknowledged
//   result_ack    in   1       consumer takes the result
//   illegal       out  1       registered with result; set for bad opcodes
//   flag_z/n/c    out  1 each  only when SHIFT_FLAGS_EN is defined
//
// Configuration:
//   SHIFT_FLAGS_EN - defining this macro adds the zero, negative and carry
//   flag outputs. The flags are registered together with result.
// ============================================================================
module shift_rotate_seq #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              start,
    output logic              ready,
    input  logic [2:0]        opcode,
    input  logic [DATA_W-1:0] operand,
    input  logic [CNT_W-1:0]  count,
    output logic [DATA_W-1:0] rot_in,
    output logic [4:0]        rot_amt,
    input  logic [DATA_W-1:0] rot_out,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    input  logic              result_ack,
`ifdef SHIFT_FLAGS_EN
    output logic              illegal,
    output logic              flag_z,
    output logic              flag_n,
    output logic              flag_c
`else
    output logic              illegal
`endif
);

    localparam logic [2:0] OP_ROR  = 3'b000;
    localparam logic [2:0] OP_ROL  = 3'b001;
    localparam logic [2:0] OP_SHR  = 3'b010;
    localparam logic [2:0] OP_SHL  = 3'b011;
    localparam logic [2:0] OP_SHRA = 3'b100;

    // S_STAGE is the cycle in which the staged request is turned into
    // rotator drive. This keeps rot_in and rot_amt registered outputs.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_STAGE = 2'd1,
        S_EXEC  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t            state_reg;
    logic [2:0]        op_reg;
    logic [DATA_W-1:0] opnd_reg;
    logic [CNT_W-1:0]  cnt_reg;

    // Derived view of the staged request
    logic [4:0]        amt_n;      // count mod 32
    logic              amt_big;    // count >= 32
    logic              is_left;    // ROL/SHL use the complementary amount
    logic              sign_bit;
    logic [DATA_W-1:0] shr_mask;   // ones where SHR keeps rotated bits
    logic [DATA_W-1:0] shl_mask;   // ones where SHL keeps rotated bits
    logic [DATA_W-1:0] result_next;
    logic              illegal_next;

    assign amt_n    = cnt_reg[4:0];
    assign amt_big  = |cnt_reg[CNT_W-1:5];
    assign is_left  = (op_reg == OP_ROL) || (op_reg == OP_SHL);
    assign sign_bit = opnd_reg[DATA_W-1];
    assign shr_mask = {DATA_W{1'b1}} >> amt_n;
    assign shl_mask = {DATA_W{1'b1}} << amt_n;

    assign ready = (state_reg == S_IDLE);

    // Post-process the rotator output. For amount 0 the rotator output is
    // undefined, so the staged operand is used directly instead.
    always_comb begin
        result_next  = opnd_reg;
        illegal_next = 1'b0;
        case (op_reg)
            OP_ROR, OP_ROL: begin
                if (amt_n != 5'd0)
                    result_next = rot_out;
            end
            OP_SHR: begin
                if (amt_big)
                    result_next = '0;
                else if (amt_n != 5'd0)
                    result_next = rot_out & shr_mask;
            end
            OP_SHL: begin
                if (amt_big)
                    result_next = '0;
                else if (amt_n != 5'd0)
                    result_next = rot_out & shl_mask;
            end
            OP_SHRA: begin
                if (amt_big)
                    result_next = {DATA_W{sign_bit}};
                else if (amt_n != 5'd0)
                    result_next = (rot_out & shr_mask) |
                                  ({DATA_W{sign_bit}} & ~shr_mask);
            end
            default: begin
                illegal_next = 1'b1;
            end
        endcase
    end

`ifdef SHIFT_FLAGS_EN
    logic [4:0] idx_right;   // n-1: last bit leaving the bottom
    logic [4:0] idx_left;    // 32-n: last bit leaving the top
    logic       carry_next;

    assign idx_right = amt_n - 5'd1;
    assign idx_left  = 5'd0 - amt_n;

    always_comb begin
        carry_next = 1'b0;
        case (op_reg)
            OP_ROR: begin
                if (amt_n != 5'd0)
                    carry_next = opnd_reg[idx_right];
            end
            OP_ROL: begin
                if (amt_n != 5'd0)
                    carry_next = opnd_reg[idx_left];
            end
            OP_SHR: begin
                if (!amt_big && amt_n != 5'd0)
                    carry_next = opnd_reg[idx_right];
            end
            OP_SHL: begin
                if (!amt_big && amt_n != 5'd0)
                    carry_next = opnd_reg[idx_left];
            end
            OP_SHRA: begin
                if (amt_big)
                    carry_next = sign_bit;
                else if (amt_n != 5'd0)
                    carry_next = opnd_reg[idx_right];
            end
            default: carry_next = 1'b0;
        endcase
    end
`endif

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_reg    <= S_IDLE;
            op_reg       <= 3'b000;
            opnd_reg     <= '0;
            cnt_reg      <= '0;
            rot_in       <= '0;
            rot_amt      <= 5'd0;
            result       <= '0;
            result_valid <= 1'b0;
            illegal      <= 1'b0;
`ifdef SHIFT_FLAGS_EN
            flag_z       <= 1'b0;
            flag_n       <= 1'b0;
            flag_c       <= 1'b0;
`endif
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        op_reg    <= opcode;
                        opnd_reg  <= operand;
                        cnt_reg   <= count;
                        state_reg <= S_STAGE;
                    end
                end
                S_STAGE: begin
                    rot_in    <= opnd_reg;
                    // Left operations are rotate-right by (32-n) mod 32
                    rot_amt   <= is_left ? (5'd0 - amt_n) : amt_n;
                    state_reg <= S_EXEC;
                end
                S_EXEC: begin
                    result       <= result_next;
                    illegal      <= illegal_next;
                    result_valid <= 1'b1;
`ifdef SHIFT_FLAGS_EN
                    flag_z       <= (result_next == '0);
                    flag_n       <= result_next[DATA_W-1];
                    flag_c       <= carry_next;
`endif
                    state_reg    <= S_HOLD;
                end
                S_HOLD: begin
                    // The result keeps its value after the ack. Only the
                    // valid and illegal indications drop.
                    if (result_ack) begin
                        result_valid <= 1'b0;
                        illegal      <= 1'b0;
                        state_reg    <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_rotate_seq.sv
// ============================================================================
// tb_shift_rotate_seq
// ----------------------------------------------------------------------------
// Testbench for shift_rotate_seq. It models the external rotate-right datapath.
// For amount 0 the model returns a poison value, because the sequencer must
// ignore the rotator at that amount. Results are compared against an
// arithmetic reference model. Directed cases run first, followed by
// randomized requests.
// ============================================================================
module tb_shift_rotate_seq;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        start = 1'b0;
    logic        ready;
    logic [2:0]  opcode = 3'b000;
    logic [31:0] operand = 32'h0;
    logic [5:0]  count = 6'd0;
    logic [31:0] rot_in;
    logic [4:0]  rot_amt;
    logic [31:0] rot_out;
    logic [31:0] result;
    logic        result_valid;
    logic        result_ack = 1'b0;
    logic        illegal;
`ifdef SHIFT_FLAGS_EN
    logic        flag_z;
    logic        flag_n;
    logic        flag_c;
`endif

    int tests  = 0;
    int errors = 0;

    always #5 clock = ~clock;

    // Rotate-right datapath model
    assign rot_out = (rot_amt == 5'd0) ? 32'hDEAD_BEEF
                   : ((rot_in >> rot_amt) | (rot_in << (6'd32 - {1'b0, rot_amt})));

    shift_rotate_seq #(.DATA_W(32), .CNT_W(6)) dut (
        .clock        (clock),
        .clear        (clear),
        .start        (start),
        .ready        (ready),
        .opcode       (opcode),
        .operand      (operand),
        .count        (count),
        .rot_in       (rot_in),
        .rot_amt      (rot_amt),
        .rot_out      (rot_out),
        .result       (result),
        .result_valid (result_valid),
        .result_ack   (result_ack),
`ifdef SHIFT_FLAGS_EN
        .illegal      (illegal),
        .flag_z       (flag_z),
        .flag_n       (flag_n),
        .flag_c       (flag_c)
`else
        .illegal      (illegal)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_result(input logic [2:0] op, input logic [31:0] x,
                                                 input int cnt);
        int n;
        n = cnt % 32;
        case (op)
            3'd0: return (x >> n) | (x << (32 - n));
            3'd1: return (x << n) | (x >> (32 - n));
            3'd2: return (cnt >= 32) ? 32'h0 : (x >> cnt);
            3'd3: return (cnt >= 32) ? 32'h0 : (x << cnt);
            3'd4: return (cnt >= 32) ? (x[31] ? 32'hFFFF_FFFF : 32'h0)
                                     : 32'($signed(x) >>> cnt);
            default: return x;
        endcase
    endfunction

    function automatic logic model_carry(input logic [2:0] op, input logic [31:0] x,
                                         input int cnt);
        int n;
        n = cnt % 32;
        if (op > 3'd4) return 1'b0;
        if (op == 3'd4 && cnt >= 32) return x[31];
        if ((op == 3'd2 || op == 3'd3) && cnt >= 32) return 1'b0;
        if (n == 0) return 1'b0;
        if (op == 3'd1 || op == 3'd3) return x[32 - n];
        return x[n - 1];
    endfunction

    function automatic int model_amt(input logic [2:0] op, input int cnt);
        int n;
        n = cnt % 32;
        if (op == 3'd1 || op == 3'd3) return (32 - n) % 32;
        return n;
    endfunction

    // One full transaction. Called at a falling edge with the DUT idle, and
    // returns at a falling edge right after the ack, so a following call
    // issues its start in the very next cycle.
    task automatic do_op(input logic [2:0] op, input logic [31:0] x, input int cnt,
                         input int hold_cycles);
        logic [31:0] exp_r;
        exp_r = model_result(op, x, cnt);
        check("ready_idle", 32'(ready), 32'd1);
        start = 1'b1; opcode = op; operand = x; count = 6'(cnt);
        @(negedge clock);
        // edge k passed: start accepted; scramble inputs and poke a stray ack
        start = 1'b0; opcode = 3'($urandom); operand = $urandom; count = 6'($urandom);
        result_ack = 1'($urandom_range(0, 1));
        check("ready_busy", 32'(ready), 32'd0);
        check("valid_k", 32'(result_valid), 32'd0);
        @(negedge clock);
        result_ack = 1'($urandom_range(0, 1));
        check("valid_k1", 32'(result_valid), 32'd0);
        if (op <= 3'd4) begin
            check("rot_in", rot_in, x);
            check("rot_amt", 32'(rot_amt), 32'(model_amt(op, cnt)));
        end
        @(negedge clock);
        result_ack = 1'b0;
        check("valid_k2", 32'(result_valid), 32'd1);
        check("result", result, exp_r);
        check("illegal", 32'(illegal), 32'(op > 3'd4));
`ifdef SHIFT_FLAGS_EN
        check("flag_z", 32'(flag_z), 32'(exp_r == 32'h0));
        check("flag_n", 32'(flag_n), 32'(exp_r[31]));
        check("flag_c", 32'(flag_c), 32'(model_carry(op, x, cnt)));
`endif
        for (int i = 0; i < hold_cycles; i++) begin
            start = 1'b1; opcode = 3'($urandom); operand = $urandom; count = 6'($urandom);
            @(negedge clock);
            check("hold_result", result, exp_r);
            check("hold_valid", 32'(result_valid), 32'd1);
            check("hold_ready", 32'(ready), 32'd0);
        end
        start = 1'b0;
        result_ack = 1'b1;
        @(negedge clock);
        result_ack = 1'b0;
        check("ack_valid", 32'(result_valid), 32'd0);
        check("ack_illegal", 32'(illegal), 32'd0);
        check("ack_result", result, exp_r);
        check("ack_ready", 32'(ready), 32'd1);
        $display("[TB] op=%0d operand=0x%08h count=%0d result=0x%08h expected=0x%08h",
                 op, x, cnt, result, exp_r);
    endtask

    initial begin
        // Reset state
        #1;
        check("rst_result", result, 32'h0);
        check("rst_valid", 32'(result_valid), 32'd0);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_rot_amt", 32'(rot_amt), 32'd0);
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);

        // Directed cases
        do_op(3'd0, 32'h0000_00F1, 4, 0);
        do_op(3'd1, 32'h8000_0001, 1, 1);
        do_op(3'd1, 32'h8000_0001, 0, 0);
        do_op(3'd4, 32'h8000_0000, 40, 0);
        do_op(3'd2, 32'h8000_0000, 40, 0);
        do_op(3'd0, 32'h0000_00F1, 36, 0);
        do_op(3'd2, 32'hF000_000F, 32, 0);
        do_op(3'd3, 32'hF000_000F, 31, 0);
        do_op(3'd4, 32'h8000_0010, 4, 5);   // long hold, then back-to-back start
        do_op(3'd2, 32'h1234_5678, 0, 0);
        do_op(3'd7, 32'h1234_5678, 9, 2);
        do_op(3'd3, 32'hC000_0000, 1, 0);

        // Reset during EXEC aborts the operation
        start = 1'b1; opcode = 3'd0; operand = 32'hA5A5_0001; count = 6'd3;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        clear = 1'b0;
        #1;
        check("abort_result", result, 32'h0);
        check("abort_rot_in", rot_in, 32'h0);
        check("abort_rot_amt", 32'(rot_amt), 32'd0);
        check("abort_valid", 32'(result_valid), 32'd0);
        check("abort_illegal", 32'(illegal), 32'd0);
        check("abort_ready", 32'(ready), 32'd1);
        @(negedge clock);
        clear = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("abort_no_valid", 32'(result_valid), 32'd0);
        end
        check("abort_ready_after", 32'(ready), 32'd1);

        // Randomized requests
        for (int t = 0; t < 150; t++) begin
            logic [2:0]  rop;
            logic [31:0] rx;
            int          rc;
            rop = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7))
                                              : 3'($urandom_range(0, 4));
            case ($urandom_range(0, 3))
                0: rx = 32'h8000_0000 | $urandom;
                1: rx = $urandom & 32'h7FFF_FFFF;
                default: rx = $urandom;
            endcase
            rc = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 63));
            do_op(rop, rx, rc, int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
